clb_conf_loader: RTL and testbench

- Writer-side initiator for the CLB configuration registers (indices 32..36) of the multiport register file.
- Accepts a load command plus a stream of 32-bit words and issues them on the file's conf write port (write_enable_conf / write_addr_conf / write_data_conf).
- Optionally reads the words back through one file read port and compares them against a shadow buffer.
- On completion, pulses clb_go so the CLB/CHM starts with the new configuration.

---
 rtl/clb_conf_loader_pkg.sv | 21 ++
 rtl/clb_conf_loader_if.sv | 43 ++++
 rtl/clb_conf_shadow.sv | 32 +++
 rtl/clb_conf_loader.sv | 147 ++++++++++++++
 tb/tb_clb_conf_loader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clb_conf_loader_pkg.sv
// Constants and FSM encoding shared by the CLB configuration loader, the CLB/CHM
// side and the multiport register file.
package clb_conf_loader_pkg;

    localparam int         CONF_BASE       = 32;
    localparam int         CONF_NUM        = 5;
    localparam logic [2:0] ERR_ILLEGAL_CMD = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Register-file address of configuration register idx.
    function automatic logic [5:0] conf_addr(input logic [5:0] base, input logic [2:0] idx);
        return base + {3'b000, idx};
    endfunction

endpackage

// File: rtl/clb_conf_loader_if.sv
// Command, data-stream, conf-write and readback signals of the CLB configuration loader.
interface clb_conf_loader_if #(
    parameter int WIDTH = 32
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_first;
    logic [2:0]       cmd_count;
    logic             cmd_verify;
    logic             data_valid;
    logic             data_ready;
    logic [WIDTH-1:0] data_in;
    logic             write_enable_conf;
    logic [5:0]       write_addr_conf;
    logic [WIDTH-1:0] write_data_conf;
    logic [5:0]       read_addr;
    logic [WIDTH-1:0] read_data;
    logic             busy;
    logic             done;
    logic             clb_go;
    logic             error;
    logic [2:0]       err_index;

    // Host / register-file side.
    modport master (
        output cmd_valid, cmd_first, cmd_count, cmd_verify,
        output data_valid, data_in, read_data,
        input  cmd_ready, data_ready,
        input  write_enable_conf, write_addr_conf, write_data_conf, read_addr,
        input  busy, done, clb_go, error, err_index
    );

    // Loader side.
    modport slave (
        input  cmd_valid, cmd_first, cmd_count, cmd_verify,
        input  data_valid, data_in, read_data,
        output cmd_ready, data_ready,
        output write_enable_conf, write_addr_conf, write_data_conf, read_addr,
        output busy, done, clb_go, error, err_index
    );

endinterface

// File: rtl/clb_conf_shadow.sv
// Copy of the words written by the current load, read back combinationally while
// the loader verifies the register file contents.
module clb_conf_shadow
    import clb_conf_loader_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CONF_NUM = clb_conf_loader_pkg::CONF_NUM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       ridx,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [CONF_NUM];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CONF_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(widx) < CONF_NUM)) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = (int'(ridx) < CONF_NUM) ? mem[ridx] : '0;

endmodule

// File: rtl/clb_conf_loader.sv
// Loads a burst of words into the CLB configuration registers of the register file,
// optionally reads them back for comparison, then starts the CLB with clb_go.
module clb_conf_loader
    import clb_conf_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CONF_BASE = clb_conf_loader_pkg::CONF_BASE,
    parameter int CONF_NUM  = clb_conf_loader_pkg::CONF_NUM
) (
    input  logic             clk,
    input  logic             reset,
    clb_conf_loader_if.slave bus
);

    localparam logic [5:0] BASE_ADDR = 6'(CONF_BASE);

    state_t           state;
    logic [2:0]       first;
    logic [2:0]       count;
    logic             verify;
    logic [2:0]       wr_idx;
    logic [2:0]       vr_idx;
    logic [WIDTH-1:0] shadow_rd;
    logic             cmd_xfer;
    logic             data_xfer;
    logic             cmd_illegal;
    logic [3:0]       cmd_end;

    assign cmd_xfer    = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign data_xfer   = (state == WRITE) && bus.data_valid && bus.data_ready;
    assign cmd_end     = {1'b0, bus.cmd_first} + {1'b0, bus.cmd_count};
    assign cmd_illegal = (bus.cmd_count == 3'd0)
                      || (bus.cmd_first > 3'(CONF_NUM - 1))
                      || (cmd_end > 4'(CONF_NUM));

    clb_conf_shadow #(
        .WIDTH    (WIDTH),
        .CONF_NUM (CONF_NUM)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (data_xfer),
        .widx  (wr_idx),
        .wdata (bus.data_in),
        .ridx  (vr_idx),
        .rdata (shadow_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            first                 <= '0;
            count                 <= '0;
            verify                <= 1'b0;
            wr_idx                <= '0;
            vr_idx                <= '0;
            bus.cmd_ready         <= 1'b1;
            bus.data_ready        <= 1'b0;
            bus.write_enable_conf <= 1'b0;
            bus.write_addr_conf   <= '0;
            bus.write_data_conf   <= '0;
            bus.read_addr         <= '0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.clb_go            <= 1'b0;
            bus.error             <= 1'b0;
            bus.err_index         <= '0;
        end else begin
            bus.done              <= 1'b0;
            bus.clb_go            <= 1'b0;
            bus.write_enable_conf <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmd_xfer) begin
                        first         <= bus.cmd_first;
                        count         <= bus.cmd_count;
                        verify        <= bus.cmd_verify;
                        wr_idx        <= '0;
                        vr_idx        <= '0;
                        bus.busy      <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        if (cmd_illegal) begin
                            bus.error     <= 1'b1;
                            bus.err_index <= ERR_ILLEGAL_CMD;
                            bus.done      <= 1'b1;
                            state         <= FINISH;
                        end else begin
                            bus.error      <= 1'b0;
                            bus.err_index  <= '0;
                            bus.data_ready <= 1'b1;
                            state          <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (data_xfer) begin
                        bus.write_enable_conf <= 1'b1;
                        bus.write_addr_conf   <= conf_addr(BASE_ADDR, first) + {3'b000, wr_idx};
                        bus.write_data_conf   <= bus.data_in;
                        wr_idx                <= wr_idx + 3'd1;
                        if ((wr_idx + 3'd1) == count) begin
                            bus.data_ready <= 1'b0;
                        end
                    end
                    // data_ready already dropped, so this strobe carries the last word.
                    if (bus.write_enable_conf && !bus.data_ready) begin
                        bus.read_addr <= conf_addr(BASE_ADDR, first);
                        if (verify) begin
                            state <= VERIFY;
                        end else begin
                            bus.done   <= 1'b1;
                            bus.clb_go <= 1'b1;
                            state      <= FINISH;
                        end
                    end
                end

                VERIFY: begin
                    if (bus.read_data != shadow_rd) begin
                        bus.error     <= 1'b1;
                        bus.err_index <= first + vr_idx;
                        bus.done      <= 1'b1;
                        state         <= FINISH;
                    end else if ((vr_idx + 3'd1) == count) begin
                        bus.done   <= 1'b1;
                        bus.clb_go <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        vr_idx        <= vr_idx + 3'd1;
                        bus.read_addr <= bus.read_addr + 6'd1;
                    end
                end

                FINISH: begin
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clb_conf_loader.sv
// Scoreboard bench for clb_conf_loader with a behavioural register file and load model.
module tb_clb_conf_loader;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       go;
        logic       err;
        logic [2:0] idx;
        int         rel;
        bit         from_acc;
    } dn_t;

    localparam logic [63:0] RST_OUTS = 64'd1 << 53;
    localparam logic [5:0]  NO_BAD   = 6'd63;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int acc_cyc = 0;
    int last_done_cyc = -10;
    int done_cnt = 0;
    bit acc_pend = 0;
    bit acc_ill = 0;
    bit post_done = 0;
    bit hold_flag = 0;
    logic [5:0] corrupt_addr = NO_BAD;

    logic [31:0] rf     [64];
    logic [31:0] ref_rf [64];
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    clb_conf_loader_if #(.WIDTH(32)) bus ();

    clb_conf_loader #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: registered write, combinational read, optional corrupted read.
    always @(posedge clk) begin
        if (bus.write_enable_conf) rf[bus.write_addr_conf] <= bus.write_data_conf;
    end
    assign bus.read_data = (bus.read_addr == corrupt_addr) ? ~rf[bus.read_addr] : rf[bus.read_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] outs();
        return {11'd0, bus.cmd_ready, bus.data_ready, bus.write_enable_conf, bus.write_addr_conf,
                bus.write_data_conf, bus.read_addr, bus.busy, bus.done, bus.clb_go, bus.error,
                bus.err_index};
    endfunction

    task automatic check_rf();
        for (int i = 32; i < 37; i++) check($sformatf("regfile_%0d", i), rf[i], ref_rf[i]);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (acc_pend) begin
                check("error_after_accept", {bus.error, acc_ill ? bus.err_index : 3'd0},
                      {acc_ill, acc_ill ? 3'd7 : 3'd0});
                acc_pend = 0;
            end
            if (post_done) begin
                check("idle_after_done", {bus.busy, bus.cmd_ready}, 2'b01);
                post_done = 0;
            end
            if (bus.busy) check("cmd_ready_while_busy", bus.cmd_ready, 1'b0);
            if (bus.write_enable_conf) begin
                strobe_cyc = cyc;
                check("strobe_addr_range",
                      (bus.write_addr_conf >= 6'd32) && (bus.write_addr_conf <= 6'd36), 1'b1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_strobe", bus.write_addr_conf, 6'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("strobe_addr", bus.write_addr_conf, w.addr);
                    check("strobe_data", bus.write_data_conf, w.data);
                end
            end
            if (bus.clb_go) check("clb_go_with_done", bus.done, 1'b1);
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
                post_done = 1;
                if (exp_dn.size() == 0) begin
                    check("unexpected_done", bus.done, 1'b0);
                end else begin
                    dn_t d;
                    d = exp_dn.pop_front();
                    check("done_status", {bus.clb_go, bus.error, bus.err_index}, {d.go, d.err, d.idx});
                    check("done_timing", cyc, d.from_acc ? acc_cyc + d.rel : strobe_cyc + d.rel);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (hold_flag) check("held_cmd_accept_cycle", cyc, last_done_cyc + 1);
                acc_cyc  = cyc + 1;
                acc_ill  = (bus.cmd_count == 0) || (bus.cmd_first > 4) ||
                           (int'(bus.cmd_first) + int'(bus.cmd_count) > 5);
                acc_pend = 1;
            end
        end
    end

    task automatic run_cmd(input int f, input int c, input bit v, input int gap, input logic [5:0] bad,
                           input logic [31:0] base, input int stop, input bit hold,
                           input int nf, input int nc, input bit nv);
        logic [31:0] w [5];
        bit ill, vld, rdy, tog;
        int k, guard, target, lim, kb;
        dn_t d;
        ill = (c == 0) || (f > 4) || (f + c > 5);
        for (int i = 0; i < 5; i++) w[i] = (base != 0) ? base + 32'(i) : $urandom;
        corrupt_addr = bad;
        lim = (stop < c) ? stop : c;
        if (ill) begin
            d = '{1'b0, 1'b1, 3'd7, 0, 1'b1};
        end else begin
            for (int i = 0; i < c; i++) exp_wr.push_back('{6'(32 + f + i), w[i]});
            for (int i = 0; i < lim; i++) ref_rf[32 + f + i] = w[i];
            kb = -1;
            if (v) begin
                for (int i = c - 1; i >= 0; i--) if (6'(32 + f + i) == bad) kb = i;
            end
            if (!v)           d = '{1'b1, 1'b0, 3'd0, 1, 1'b0};
            else if (kb >= 0) d = '{1'b0, 1'b1, 3'(f + kb), kb + 2, 1'b0};
            else              d = '{1'b1, 1'b0, 3'd0, c + 1, 1'b0};
        end
        exp_dn.push_back(d);
        target = done_cnt + 1;

        bus.data_valid = 1'($urandom_range(0, 1));
        bus.data_in    = $urandom;
        bus.cmd_first  = 3'(f);
        bus.cmd_count  = 3'(c);
        bus.cmd_verify = v;
        bus.cmd_valid  = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.cmd_ready && guard < 100);
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", 1'b0, 1'b1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        hold_flag = hold;
        if (hold) begin
            bus.cmd_first  = 3'(nf);
            bus.cmd_count  = 3'(nc);
            bus.cmd_verify = nv;
        end else begin
            bus.cmd_valid = 1'b0;
        end

        if (!ill) begin
            k = 0;
            guard = 0;
            tog = 1;
            while (k < lim && guard < 300) begin
                if (gap < 0) begin
                    vld = tog;
                    tog = !tog;
                end else begin
                    vld = ($urandom_range(0, 99) >= gap);
                end
                bus.data_valid = vld;
                bus.data_in    = vld ? w[k] : $urandom;
                @(negedge clk);
                rdy = bus.data_ready;
                @(posedge clk);
                #1;
                if (vld && rdy) k++;
                guard++;
            end
            if (k < lim) check("data_accept_timeout", k, lim);
            if (stop < c) begin
                bus.data_valid = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                bus.data_valid = 1'b1;
                bus.data_in    = $urandom;
                @(posedge clk);
                #1;
            end
            bus.data_valid = 1'b0;
        end

        guard = 0;
        while (done_cnt < target && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
        check_rf();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rf[i]     = '0;
            ref_rf[i] = '0;
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_first  = '0;
        bus.cmd_count  = '0;
        bus.cmd_verify = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), RST_OUTS);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_outputs", outs(), RST_OUTS);

        // Full burst, streaming, no verify.
        run_cmd(0, 5, 0, 0, NO_BAD, 32'hA0, 5, 0, 0, 0, 0);
        // Two words with a one-cycle gap, verified.
        run_cmd(2, 2, 1, -1, NO_BAD, 32'h0, 5, 0, 0, 0, 0);
        // Range overruns the configuration block.
        run_cmd(3, 3, 0, 0, NO_BAD, 32'h0, 5, 0, 0, 0, 0);
        // Readback corrupted at address 33.
        run_cmd(0, 3, 1, 0, 6'd33, 32'h0, 5, 0, 0, 0, 0);
        // Failing load with the next command held pending throughout.
        run_cmd(1, 2, 1, 0, 6'd34, 32'h0, 5, 1, 0, 1, 0);
        run_cmd(0, 1, 0, 0, NO_BAD, 32'h0, 5, 0, 0, 0, 0);

        // Reset in the middle of a four-word load.
        run_cmd(0, 4, 0, 0, NO_BAD, 32'h0, 2, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midop_reset_outputs", outs(), RST_OUTS);
        exp_wr.delete();
        exp_dn.delete();
        acc_pend  = 0;
        post_done = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_rf();
        repeat (3) @(posedge clk);
        #1;
        run_cmd(1, 3, 1, 20, NO_BAD, 32'h0, 5, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_cmd($urandom_range(0, 6), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 60),
                    ($urandom_range(0, 2) == 0) ? NO_BAD : 6'(32 + $urandom_range(0, 4)),
                    32'h0, 5, 0, 0, 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("pending_strobes", exp_wr.size(), 0);
        check("pending_dones", exp_dn.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
